bnn_act_packer: RTL and testbench
=================================

Name: bnn_act_packer

Overview:
- Sequential packer for the BNN datapath. It collects the 1-bit activations produced by the BNN unit (BNNResult[0] with threshold enabled) into packed 32-bit words.
- The packed words are the input operands for the next layer's XOR/XNOR-popcount, so the block performs the write-side packing that the popcount reads back.
- Bit 0 of each word is the first activation received, so lanes line up with the popcount's low-lane (i < matrix_size) masking.
- It sits between the execute-stage BNN result and the store/writeback path, and uses a valid/ready handshake on both sides.

Parameters:
- WORD_W, 32, packed word width.
- CNT_W, 6, width of bit counter and length fields (holds 0..32).
- PACK_LEN_RST, 9, reset pack length; matches the 3x3 matrix_size reset default.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; one clock, reset is synchronous and active-high.
- pl_WE  in  1  pack-length write enable (I-type config instruction).
- ExtImmE  in  32  config write data; low bits give the pack length.
- bit_valid  in  1  activation bit offered.
- bit_in  in  1  activation bit.
- bit_ready  out  1  packer can accept a bit.
- flush  in  1  single-cycle pulse: emit the partial word.
- word_valid  out  1  packed word available.
- word_ready  in  1  consumer accepts the word.
- word_data  out  WORD_W  packed word; bits at index >= word_bits are 0.
- word_bits  out  CNT_W  number of valid bits in word_data (1..32).
- pack_len  out  CNT_W  current pack length readback.
- cfg_err  out  1  one-cycle pulse: config write rejected.

Behaviour:
- Reset values:
  - word_valid=0, word_data=0, word_bits=0, cfg_err=0.
  - pack_len=PACK_LEN_RST; accumulator=0; count=0; state=FILL.
  - bit_ready is 1 in the first cycle after reset.
- Storage: accumulator register acc[31:0] with count cnt, plus one output slot (word_data/word_bits/word_valid).
- Bit accept: a bit is accepted when bit_valid && bit_ready. It is written to acc[cnt], then cnt increments.
- Word complete: occurs when an accept makes cnt==pack_len, or when flush is high with cnt>0 after any same-cycle accept.
- FSM states:
  - FILL: bit_ready=1. On completion:
    - If the slot is empty or is being popped this edge (word_valid && word_ready), move acc to the slot at the same edge, clear acc and cnt, and stay in FILL. word_valid is 1 in the next cycle (latency 1 from the completing bit).
    - Otherwise go to FULL and hold acc.
  - FULL: bit_ready=0. On the edge where the slot is popped, move acc to the slot, clear acc and cnt, and go to FILL. word_valid stays 1 with the new data; bit_ready returns to 1 in the next cycle.
- Output handshake: while word_valid=1 and word_ready=0, word_data and word_bits hold stable. A pop with no replacement clears word_valid.
- Flush rules:
  - With cnt==0, flush is a no-op.
  - In FULL, flush is ignored (the held word is already complete).
  - A bit accepted in the same cycle as flush is included in the flushed word.
- Config write (pl_WE):
  - Accepted only when state=FILL, cnt==0 and no bit is accepted in that cycle.
  - pack_len = 32 if ExtImmE==0 or ExtImmE>32 (unsigned); otherwise ExtImmE[5:0].
  - Otherwise the write is dropped, cfg_err pulses for one cycle, and pack_len is unchanged.
  - The new value governs the next bit accepted.
- Widths: cnt compares in CNT_W bits; word_bits=32 is encoded as 6'b100000. No wrap beyond 32 is possible.
- Reset mid-operation: the partial word and the slot contents are discarded with no output.

Decomposition:
- Shared package bnn_pkg holds:
  - WORD_W, CNT_W, PACK_LEN_RST.
  - typedef enum {FILL, FULL} pack_state_t.
  - Function clamp_pack_len(logic [31:0]) returning CNT_W bits.
- One natural sub-module, bnn_word_slot: a single-entry valid/ready holding register (load, pop, data/bits outputs).
- FSM and accumulator stay in bnn_act_packer.

Test Plan:
- Default length, word_ready=1: after reset, send bits 1,0,1,1,0,0,1,0,1 on consecutive cycles -> one cycle after the 9th bit, word_valid=1, word_data=0x0000014D, word_bits=9. bit_ready stays 1 throughout.
- Backpressure: word_ready=0, stream 18 bits of 1 -> first word 0x000001FF is held stable; bit_ready=0 after the 18th bit. Raise word_ready -> words 0x1FF then 0x1FF are popped in order, and bit_ready returns to 1 the cycle after the second load.
- Length clamp: pl_WE with ExtImmE=40 -> pack_len=32. Then 32 ones -> word_data=0xFFFFFFFF, word_bits=6'b100000. ExtImmE=0 -> pack_len=32. ExtImmE=4 -> pack_len=4.
- Flush: len 9, send 1,1,0,1,0 then flush -> word_data=0x0000000B, word_bits=5. A second flush with cnt=0 produces no word. Flush together with a 6th bit=1 -> 0x2B, word_bits=6.
- Config while busy: after 3 bits, pulse pl_WE with ExtImmE=16 -> cfg_err=1 for one cycle, pack_len stays 9, and the current word completes at 9 bits.
- Mid-operation reset: after 4 bits, assert reset for one cycle -> word_valid=0 and pack_len=9 (a len-4 config is also reset). The next 9 bits form a fresh word with no residue from the earlier bits.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants, state type and config helper for the BNN activation packer.
package bnn_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 6;
  localparam logic [CNT_W-1:0] PACK_LEN_RST = 6'd9;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } pack_state_t;

  // Zero and anything past one full word both mean "use the whole word".
  function automatic logic [CNT_W-1:0] clamp_pack_len(input logic [31:0] v);
    if ((v == 32'd0) || (v > 32'd32)) begin
      return CNT_W'(32);
    end
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/bnn_act_packer_if.sv
// Handshake and config bundle between the execute-stage BNN result and the packer.
interface bnn_act_packer_if;
  import bnn_pkg::*;

  logic                pl_WE;
  logic [31:0]         ExtImmE;
  logic                bit_valid;
  logic                bit_in;
  logic                bit_ready;
  logic                flush;
  logic                word_valid;
  logic                word_ready;
  logic [WORD_W-1:0]   word_data;
  logic [CNT_W-1:0]    word_bits;
  logic [CNT_W-1:0]    pack_len;
  logic                cfg_err;

  modport master (
    output pl_WE, ExtImmE, bit_valid, bit_in, flush, word_ready,
    input  bit_ready, word_valid, word_data, word_bits, pack_len, cfg_err
  );

  modport slave (
    input  pl_WE, ExtImmE, bit_valid, bit_in, flush, word_ready,
    output bit_ready, word_valid, word_data, word_bits, pack_len, cfg_err
  );

endinterface

// File: rtl/bnn_word_slot.sv
// Single-entry valid/ready holding register for completed packed words.
module bnn_word_slot
  import bnn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_bits,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_bits
);

  logic              r_valid;
  logic [WORD_W-1:0] r_data;
  logic [CNT_W-1:0]  r_bits;

  // A load on the pop edge replaces the entry, so load takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_bits  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_bits  <= i_bits;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_bits  = r_bits;

endmodule

// File: rtl/bnn_act_packer.sv
// Packs 1-bit BNN activations LSB-first into words for the next layer's popcount.
//   state | meaning
//   FILL  | accepting bits into the accumulator
//   FULL  | accumulator holds a complete word, waiting for the slot to drain
module bnn_act_packer
  import bnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  bnn_act_packer_if.slave  bus
);

  localparam logic [0:0] ST_FILL = 1'(FILL);
  localparam logic [0:0] ST_FULL = 1'(FULL);

  logic [0:0]        r_state;
  logic [WORD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_pack_len;
  logic              r_cfg_err;

  logic              w_bit_ready;
  logic              w_accept;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WORD_W-1:0] w_acc_nxt;
  logic              w_complete;
  logic              w_slot_valid;
  logic              w_pop;
  logic              w_slot_free;
  logic              w_load;
  logic              w_cfg_ok;

  assign w_bit_ready = (r_state == ST_FILL);
  assign w_accept    = bus.bit_valid && w_bit_ready;
  assign w_cnt_nxt   = r_cnt + CNT_W'(w_accept);
  assign w_acc_nxt   = w_accept ? (r_acc | (WORD_W'(bus.bit_in) << r_cnt)) : r_acc;

  // Flush looks at the count after a same-cycle accept so that bit joins the word.
  assign w_complete  = w_bit_ready &&
                       ((w_accept && (w_cnt_nxt == r_pack_len)) ||
                        (bus.flush && (w_cnt_nxt != '0)));

  assign w_pop       = w_slot_valid && bus.word_ready;
  assign w_slot_free = !w_slot_valid || w_pop;
  assign w_cfg_ok    = bus.pl_WE && w_bit_ready && (r_cnt == '0) && !w_accept;

  // FULL never accepts, so w_acc_nxt/w_cnt_nxt equal the held word there.
  always_comb begin
    w_load = 1'b0;
    if (r_state == ST_FILL) begin
      w_load = w_complete && w_slot_free;
    end else begin
      w_load = w_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FILL;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_pack_len <= PACK_LEN_RST;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= bus.pl_WE && !w_cfg_ok;
      if (w_cfg_ok) begin
        r_pack_len <= clamp_pack_len(bus.ExtImmE);
      end
      if (r_state == ST_FILL) begin
        if (w_load) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
          if (w_complete) begin
            r_state <= ST_FULL;
          end
        end
      end else if (w_pop) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_state <= ST_FILL;
      end
    end
  end

  bnn_word_slot u_slot (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (w_acc_nxt),
    .i_bits  (w_cnt_nxt),
    .i_pop   (w_pop),
    .o_valid (w_slot_valid),
    .o_data  (bus.word_data),
    .o_bits  (bus.word_bits)
  );

  assign bus.bit_ready  = w_bit_ready;
  assign bus.word_valid = w_slot_valid;
  assign bus.pack_len   = r_pack_len;
  assign bus.cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_bnn_act_packer.sv
// Scoreboard bench for bnn_act_packer: directed test-plan cases then random traffic.
module tb_bnn_act_packer;
  import bnn_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bnn_act_packer_if bus();

  bnn_act_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          bits;
  } word_t;

  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 1'b0;

  // Reference model: list of pending bits, count of words produced but not yet consumed.
  bit m_bits[$];
  int m_outstanding = 0;
  int m_len = 9;
  bit m_cfg_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_len(input logic [31:0] v);
    if (v == 0 || v > 32) return 32;
    return int'(v);
  endfunction

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic tick();
    bit   br, acc, pop, cmp;
    int   before_sz;
    word_t w;
    #1;
    if (chk_en) begin
      check("bit_ready",  bus.bit_ready,  64'(m_outstanding < 2));
      check("word_valid", bus.word_valid, 64'(m_outstanding > 0));
      check("pack_len",   bus.pack_len,   64'(m_len));
      check("cfg_err",    bus.cfg_err,    64'(m_cfg_err));
    end
    if (reset) begin
      m_bits.delete();
      m_outstanding = 0;
      m_len = 9;
      m_cfg_err = 1'b0;
      exp_q.delete();
    end else begin
      br        = (m_outstanding < 2);
      before_sz = m_bits.size();
      acc       = bus.bit_valid && br;
      pop       = (m_outstanding > 0) && bus.word_ready;
      cmp       = 1'b0;
      if (acc) m_bits.push_back(bus.bit_in);
      if (br && ((acc && m_bits.size() == m_len) || (bus.flush && m_bits.size() > 0))) begin
        w.data = 32'd0;
        w.bits = m_bits.size();
        for (int i = 0; i < m_bits.size(); i++) w.data[i] = m_bits[i];
        exp_q.push_back(w);
        m_bits.delete();
        cmp = 1'b1;
      end
      m_outstanding = m_outstanding + int'(cmp) - int'(pop);
      m_cfg_err = bus.pl_WE && !(br && before_sz == 0 && !acc);
      if (bus.pl_WE && !m_cfg_err) m_len = clamp_len(bus.ExtImmE);
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit v, input bit b, input bit fl = 1'b0,
                     input bit we = 1'b0, input logic [31:0] imm = 32'd0);
    bus.bit_valid = v;
    bus.bit_in    = b;
    bus.flush     = fl;
    bus.pl_WE     = we;
    bus.ExtImmE   = imm;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] pat, input int n);
    logic [31:0] p;
    p = pat;
    for (int i = 0; i < n; i++) cyc(1'b1, p[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  // Monitor: compares every consumed word against the scoreboard, and checks hold stability.
  initial begin
    bit          prev_held;
    logic [31:0] pd;
    logic [5:0]  pb;
    word_t       e;
    prev_held = 1'b0;
    pd = '0;
    pb = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!chk_en || reset) begin
        prev_held = 1'b0;
      end else begin
        if (prev_held) begin
          check("hold_data", bus.word_data, 64'(pd));
          check("hold_bits", bus.word_bits, 64'(pb));
        end
        if (bus.word_valid && bus.word_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%0h/%0d required=none", bus.word_data, bus.word_bits);
          end else begin
            e = exp_q.pop_front();
            check("word_data", bus.word_data, 64'(e.data));
            check("word_bits", bus.word_bits, 64'(e.bits));
          end
        end
        prev_held = bus.word_valid && !bus.word_ready;
        pd = bus.word_data;
        pb = bus.word_bits;
      end
    end
  end

  initial begin
    logic [31:0] imms [8];
    reset          = 1'b1;
    bus.bit_valid  = 1'b0;
    bus.bit_in     = 1'b0;
    bus.flush      = 1'b0;
    bus.pl_WE      = 1'b0;
    bus.ExtImmE    = 32'd0;
    bus.word_ready = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_word_data", bus.word_data, 64'd0);
    check("rst_word_bits", bus.word_bits, 64'd0);
    idle(1);
    reset = 1'b0;

    // Default length 9, consumer always ready.
    send_bits(32'h14D, 9);
    check("t1_valid", bus.word_valid, 64'd1);
    check("t1_data",  bus.word_data,  64'h14D);
    check("t1_bits",  bus.word_bits,  64'd9);
    idle(2);

    // Backpressure: 18 ones with the consumer stalled.
    bus.word_ready = 1'b0;
    send_bits(32'hFFFFFFFF, 18);
    check("t2_ready_low", bus.bit_ready, 64'd0);
    check("t2_data",      bus.word_data, 64'h1FF);
    idle(3);
    bus.word_ready = 1'b1;
    idle(4);

    // Length clamp.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd40);
    check("t3_len40", bus.pack_len, 64'd32);
    send_bits(32'hFFFFFFFF, 32);
    check("t3_data", bus.word_data, 64'hFFFFFFFF);
    check("t3_bits", bus.word_bits, 64'd32);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    check("t3_len0", bus.pack_len, 64'd32);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd4);
    check("t3_len4", bus.pack_len, 64'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd9);

    // Flush: partial word, empty flush, flush with a same-cycle bit.
    send_bits(32'h0B, 5);
    cyc(1'b0, 1'b0, 1'b1);
    check("t4_data", bus.word_data, 64'h0B);
    check("t4_bits", bus.word_bits, 64'd5);
    cyc(1'b0, 1'b0, 1'b1);
    check("t4_empty_flush", bus.word_valid, 64'd0);
    send_bits(32'h0B, 5);
    cyc(1'b1, 1'b1, 1'b1);
    check("t4b_data", bus.word_data, 64'h2B);
    check("t4b_bits", bus.word_bits, 64'd6);
    idle(2);

    // Config while a word is in progress.
    send_bits(32'h5, 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd16);
    check("t5_cfg_err", bus.cfg_err,  64'd1);
    check("t5_len",     bus.pack_len, 64'd9);
    send_bits(32'h3F, 6);
    check("t5_bits", bus.word_bits, 64'd9);
    idle(2);

    // Reset in the middle of operation.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd4);
    bus.word_ready = 1'b0;
    send_bits(32'hF, 4);
    send_bits(32'h3, 2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("t6_valid", bus.word_valid, 64'd0);
    check("t6_len",   bus.pack_len,   64'd9);
    bus.word_ready = 1'b1;
    send_bits(32'h155, 9);
    check("t6_data", bus.word_data, 64'h155);
    check("t6_bits", bus.word_bits, 64'd9);
    idle(2);

    // Random traffic.
    imms[0] = 32'd0;  imms[1] = 32'd1;  imms[2] = 32'd5;  imms[3] = 32'd9;
    imms[4] = 32'd31; imms[5] = 32'd32; imms[6] = 32'd33; imms[7] = 32'hFFFF_FFF0;
    for (int n = 0; n < 3000; n++) begin
      bus.word_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
      end else begin
        cyc(($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 7) == 7) ? $urandom : imms[$urandom_range(0, 7)]);
      end
    end

    bus.word_ready = 1'b1;
    idle(6);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
